// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyphs (active-high g..a),
// the all-off pattern and the index-width helper.
package seg_pkg;

   // Index n holds the glyph for hex digit n; bit 0 = segment a.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [7:0] SEG_OFF = 8'h00;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/seg_scan_driver_hex7seg_dec.sv
// Combinational hex nibble + decimal point -> 8-bit segment pattern {dp, g..a}.
// seg_dark darkens only g..a (leading-zero suppression); blank darkens everything.
module hex7seg_dec
   import seg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   input  logic       seg_dark,
   output logic [7:0] seg
);

   logic [7:0] seg_hi;

   always_comb begin
      seg_hi = {dp, SEG_HEX[nibble]};
      if (seg_dark) begin
         seg_hi[6:0] = SEG_OFF[6:0];
      end
      if (blank) begin
         seg_hi = SEG_OFF;
      end
      seg = ACTIVE_LOW ? ~seg_hi : seg_hi;
   end

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment driver with prescaled scan, double-buffered display data
// and registered Dis/Cs. Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int CS_ACTIVE_LOW  = 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [4*DIGITS-1:0] Value,
   input  logic [DIGITS-1:0]   Dp,
   input  logic [DIGITS-1:0]   Blank,
   input  logic                Load,
   output logic [7:0]          Dis,
   output logic [DIGITS-1:0]   Cs,
   output logic                Frame_Done,
   output logic                Pending
);

   localparam int IDX_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
   localparam int CNT_W = clog2(CLK_DIV);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [7:0]        DIS_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic [DIGITS-1:0] CS_IDLE  = {DIGITS{(CS_ACTIVE_LOW != 0)}};

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] act_val_q, act_val_d;
   logic [DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [DIGITS-1:0]   act_blank_q, act_blank_d;
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic                pend_flag_q, pend_flag_d;
   logic                frame_done_q, frame_done_d;
   logic [7:0]          dis_q, dis_d;
   logic [DIGITS-1:0]   cs_q, cs_d;

   logic                tick;
   logic                boundary;
   logic [3:0]          act_nib [DIGITS];
   logic [DIGITS-1:0]   cs_sel;
   logic [DIGITS-1:0]   lz_sup;
   logic [7:0]          dec_seg;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign act_nib[gi] = act_val_q[4*gi +: 4];
      assign cs_sel[gi]  = (idx_q == IDX_W'(gi));
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_higher;

   // Walk from the most significant digit down; digit 0 is never suppressed.
   always_comb begin
      lz_sup    = '0;
      lz_higher = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lz_sup[i] = lz_higher && (act_nib[i] == 4'h0);
         lz_higher = lz_higher && ((act_nib[i] == 4'h0) || act_blank_q[i]);
      end
   end
`else
   assign lz_sup = '0;
`endif

   hex7seg_dec #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
   ) u_dec (
      .nibble   (act_nib[idx_q]),
      .dp       (act_dp_q[idx_q]),
      .blank    (act_blank_q[idx_q]),
      .seg_dark (lz_sup[idx_q]),
      .seg      (dec_seg)
   );

   always_comb begin
      tick     = (cnt_q == CNT_LAST);
      boundary = tick && (idx_q == IDX_LAST);

      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      act_val_d    = act_val_q;
      act_dp_d     = act_dp_q;
      act_blank_d  = act_blank_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_flag_d  = pend_flag_q;

      // A load landing on the boundary bypasses the pending buffer and drops whatever was there.
      if (Load && boundary) begin
         act_val_d   = Value;
         act_dp_d    = Dp;
         act_blank_d = Blank;
         pend_flag_d = 1'b0;
      end else if (Load) begin
         pend_val_d   = Value;
         pend_dp_d    = Dp;
         pend_blank_d = Blank;
         pend_flag_d  = 1'b1;
      end else if (boundary && pend_flag_q) begin
         act_val_d   = pend_val_q;
         act_dp_d    = pend_dp_q;
         act_blank_d = pend_blank_q;
         pend_flag_d = 1'b0;
      end

      frame_done_d = boundary;
      dis_d        = dec_seg;
      cs_d         = cs_sel ^ CS_IDLE;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         act_val_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_flag_q  <= 1'b0;
         frame_done_q <= 1'b0;
         dis_q        <= DIS_IDLE;
         cs_q         <= CS_IDLE;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         act_val_q    <= act_val_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_flag_q  <= pend_flag_d;
         frame_done_q <= frame_done_d;
         dis_q        <= dis_d;
         cs_q         <= cs_d;
      end
   end

   assign Dis        = dis_q;
   assign Cs         = cs_q;
   assign Frame_Done = frame_done_q;
   assign Pending    = pend_flag_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, 4 clocks per slot, active-low outputs).
// Stimulus pushes expected {Cs, Dis} per digit slot; a monitor pops on every Cs change.
module tb_seg_scan_driver;

   localparam int DIGITS = 4;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [7:0] Z_HI = 8'hFF;
`else
   localparam logic [7:0] Z_HI = 8'hC0;
`endif

   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic [4*DIGITS-1:0] Value = '0;
   logic [DIGITS-1:0]   Dp = '0;
   logic [DIGITS-1:0]   Blank = '0;
   logic                Load = 1'b0;
   logic [7:0]          Dis;
   logic [DIGITS-1:0]   Cs;
   logic                Frame_Done;
   logic                Pending;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [11:0] exp_q [$];

   seg_scan_driver #(
      .DIGITS         (DIGITS),
      .CLK_DIV        (4),
      .SEG_ACTIVE_LOW (1),
      .CS_ACTIVE_LOW  (1)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Value      (Value),
      .Dp         (Dp),
      .Blank      (Blank),
      .Load       (Load),
      .Dis        (Dis),
      .Cs         (Cs),
      .Frame_Done (Frame_Done),
      .Pending    (Pending)
   );

   always #5 CLK = ~CLK;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
      end
   endtask

   task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
      exp_q.push_back({4'hE, d0});
      exp_q.push_back({4'hD, d1});
      exp_q.push_back({4'hB, d2});
      exp_q.push_back({4'h7, d3});
   endtask

   task automatic wait_fd(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!Frame_Done && n < 40);
      if (!Frame_Done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no Frame_Done in 40 cycles, required one pulse", tag);
      end
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(negedge CLK);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d slots never shown, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      @(posedge CLK);
      #1;
      Value = v;
      Dp    = d;
      Blank = b;
      Load  = 1'b1;
      @(posedge CLK);
      #1;
      Load = 1'b0;
      $display("load Value=%h Dp=%b Blank=%b", v, d, b);
   endtask

   task automatic release_rst();
      @(negedge CLK);
      #1;
      RST = 1'b0;
   endtask

   // Monitor: one-hot select every cycle, slot length, frame period, and scoreboard pops.
   logic [3:0]  prev_cs;
   logic [11:0] mon_e;
   int          last_slot = -1;
   int          last_fd = -1;

   initial forever begin
      @(negedge CLK);
      if (RST) begin
         prev_cs   = Cs;
         last_slot = -1;
         last_fd   = -1;
      end else begin
         chk("cs_onehot", $countones(~Cs), 1);
         if (Cs != prev_cs) begin
            if (last_slot >= 0) chk("slot_len", cyc - last_slot, 4);
            last_slot = cyc;
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               $display("slot Cs=%b Dis=%h expected Cs=%b Dis=%h", Cs, Dis, mon_e[11:8], mon_e[7:0]);
               chk("slot_cs", Cs, mon_e[11:8]);
               chk("slot_dis", Dis, mon_e[7:0]);
            end
            prev_cs = Cs;
         end
         if (Frame_Done) begin
            if (last_fd >= 0) chk("frame_period", cyc - last_fd, 16);
            last_fd = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required earlier finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values and the scan sequence straight out of reset.
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_dis", Dis, 8'hFF);
      chk("rst_cs", Cs, 4'hF);
      chk("rst_pending", Pending, 1'b0);
      chk("rst_frame_done", Frame_Done, 1'b0);
      push_frame(8'hC0, Z_HI, Z_HI, Z_HI);
      exp_q.push_back({4'hE, 8'hC0});
      release_rst();

      // Single load mid-frame: pending until the boundary, then displayed.
      wait_fd("fd_first");
      do_load(16'h1234, 4'b0000, 4'b0000);
      @(negedge CLK);
      chk("pending_set", Pending, 1'b1);
      repeat (6) @(negedge CLK);
      chk("pending_hold", Pending, 1'b1);
      wait_fd("fd_1234");
      chk("pending_clear_1234", Pending, 1'b0);
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);

      // Two loads in one frame: only the last one reaches the display.
      do_load(16'hAAAA, 4'b0000, 4'b0000);
      repeat (3) @(posedge CLK);
      do_load(16'h00F0, 4'b0000, 4'b0000);
      @(negedge CLK);
      chk("pending_overwrite", Pending, 1'b1);
      wait_fd("fd_00f0");
      chk("pending_clear_00f0", Pending, 1'b0);
      push_frame(8'hC0, 8'h8E, Z_HI, Z_HI);

      // Load on the boundary tick: next frame shows it, Pending never rises.
      repeat (15) @(posedge CLK);
      #1;
      Value = 16'h9876;
      Dp    = 4'b0010;
      Blank = 4'b0000;
      Load  = 1'b1;
      @(posedge CLK);
      #1;
      Load = 1'b0;
      $display("load Value=9876 Dp=0010 Blank=0000 on boundary");
      @(negedge CLK);
      chk("fd_at_boundary", Frame_Done, 1'b1);
      chk("pending_boundary_load", Pending, 1'b0);
      push_frame(8'h82, 8'h78, 8'h80, 8'h90);

      // Blank and decimal point.
      do_load(16'hFFFF, 4'b0001, 4'b1000);
      @(negedge CLK);
      chk("pending_blank", Pending, 1'b1);
      wait_fd("fd_blank");
      chk("pending_clear_blank", Pending, 1'b0);
      push_frame(8'h0E, 8'h8E, 8'h8E, 8'hFF);

      // Zero-heavy values (leading digits dark when suppression is built in).
      do_load(16'h0040, 4'b0000, 4'b0000);
      wait_fd("fd_0040");
      push_frame(8'hC0, 8'h99, Z_HI, Z_HI);
      do_load(16'h0000, 4'b0000, 4'b0000);
      wait_fd("fd_0000");
      push_frame(8'hC0, Z_HI, Z_HI, Z_HI);

      // Reset mid-frame with data pending: outputs idle at once, pending data lost.
      wait_drain(40);
      wait_fd("fd_pre_reset");
      do_load(16'hBEEF, 4'b0000, 4'b0000);
      @(negedge CLK);
      chk("pending_pre_reset", Pending, 1'b1);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      chk("midrst_dis", Dis, 8'hFF);
      chk("midrst_cs", Cs, 4'hF);
      chk("midrst_pending", Pending, 1'b0);
      chk("midrst_frame_done", Frame_Done, 1'b0);
      repeat (3) @(posedge CLK);
      push_frame(8'hC0, Z_HI, Z_HI, Z_HI);
      push_frame(8'hC0, Z_HI, Z_HI, Z_HI);
      release_rst();
      wait_drain(60);
      repeat (2) @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
